// File: rtl/cm3_mac_pkg.sv
// Shared widths, saturation limits and default-width clamp helpers for the CM3 MAC engine.
package cm3_mac_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_ACC_W     = 64;
    localparam int unsigned DEF_FRAC_BITS = 0;
    localparam int unsigned DEF_CNT_W     = 16;

    localparam logic signed [DEF_ACC_W-1:0]  ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic signed [DEF_ACC_W-1:0]  ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};
    localparam logic signed [DEF_DATA_W-1:0] OUT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic signed [DEF_DATA_W-1:0] OUT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    // Clamp a one-bit-wider sum back into the default accumulator range.
    function automatic logic signed [DEF_ACC_W-1:0] sat_to_acc(
        input  logic signed [DEF_ACC_W:0] val,
        output logic                      hit
    );
        hit = (val[DEF_ACC_W] != val[DEF_ACC_W-1]);
        if (!hit) return val[DEF_ACC_W-1:0];
        return val[DEF_ACC_W] ? ACC_MIN : ACC_MAX;
    endfunction

    function automatic logic signed [DEF_DATA_W-1:0] sat_to_out(
        input  logic signed [DEF_ACC_W-1:0] val,
        output logic                        hit
    );
        logic [DEF_ACC_W-DEF_DATA_W:0] hi;
        hi  = val[DEF_ACC_W-1:DEF_DATA_W-1];
        hit = !((&hi) || (~|hi));
        if (!hit) return val[DEF_DATA_W-1:0];
        return val[DEF_ACC_W-1] ? OUT_MIN : OUT_MAX;
    endfunction

endpackage

// File: rtl/cm3_mac_if.sv
// Operand/clear strobes from the AHB register slave and the MAC result/status back to it.
interface cm3_mac_if
    import cm3_mac_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
);

    logic [DATA_W-1:0] data_a;
    logic              data_a_valid;
    logic [DATA_W-1:0] data_b;
    logic              data_b_valid;
    logic              clear;
    logic [DATA_W-1:0] data_mac;
    logic              busy;
    logic              ovf;
    logic [CNT_W-1:0]  mac_cnt;

    modport master (
        output data_a, data_a_valid, data_b, data_b_valid, clear,
        input  data_mac, busy, ovf, mac_cnt
    );

    modport slave (
        input  data_a, data_a_valid, data_b, data_b_valid, clear,
        output data_mac, busy, ovf, mac_cnt
    );

endinterface

// File: rtl/cm3_mac_sat.sv
// Signed narrowing with clamp to the OUT_W range; sat_o flags that clamping occurred.
module cm3_mac_sat #(
    parameter int unsigned IN_W  = 65,
    parameter int unsigned OUT_W = 64
) (
    input  logic signed [IN_W-1:0]  val_i,
    output logic signed [OUT_W-1:0] val_o,
    output logic                    sat_o
);

    localparam logic signed [OUT_W-1:0] MaxVal = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MinVal = {1'b1, {(OUT_W-1){1'b0}}};

    // Value fits iff every bit from the output sign bit upward agrees.
    logic [IN_W-OUT_W:0] hi_bits;
    assign hi_bits = val_i[IN_W-1:OUT_W-1];

    always_comb begin
        sat_o = !((&hi_bits) || (~|hi_bits));
        val_o = val_i[OUT_W-1:0];
        if (sat_o) begin
            val_o = val_i[IN_W-1] ? MinVal : MaxVal;
        end
    end

endmodule

// File: rtl/cm3_mac_core.sv
// Paired-operand multiply-accumulate: capture/issue, multiply, saturating add, scaled output.
module cm3_mac_core
    import cm3_mac_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input logic      hclk,
    input logic      rst_n,
    cm3_mac_if.slave bus_io
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic                     a_pend_q, a_pend_d, b_pend_q, b_pend_d;
    logic                     a_avail, b_avail, issue;
    logic signed [DATA_W-1:0] a_op, b_op;
    logic signed [PROD_W-1:0] a_ext, b_ext, p_d, p_q;
    logic                     p_vld_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sat, acc_shr;
    logic signed [ACC_W:0]    acc_sum;
    logic                     acc_ovf;
    logic                     acc_upd_vld_q, acc_upd_vld_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
    logic                     ovf_q, ovf_d;
    logic signed [DATA_W-1:0] data_mac_q, data_mac_d, out_sat;
    logic                     out_ovf;

    // Clear flushes stale pend flags, but a strobe in the clear cycle still counts.
    always_comb begin
        a_avail  = bus_io.data_a_valid | (a_pend_q & ~bus_io.clear);
        b_avail  = bus_io.data_b_valid | (b_pend_q & ~bus_io.clear);
        issue    = a_avail & b_avail;
        a_op     = bus_io.data_a_valid ? bus_io.data_a : a_q;
        b_op     = bus_io.data_b_valid ? bus_io.data_b : b_q;
        a_d      = a_op;
        b_d      = b_op;
        a_pend_d = issue ? 1'b0 : a_avail;
        b_pend_d = issue ? 1'b0 : b_avail;
        a_ext    = {{DATA_W{a_op[DATA_W-1]}}, a_op};
        b_ext    = {{DATA_W{b_op[DATA_W-1]}}, b_op};
        p_d      = a_ext * b_ext;
    end

    assign acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - PROD_W){p_q[PROD_W-1]}}, p_q};
    assign acc_shr = acc_q >>> FRAC_BITS;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    cm3_mac_sat #(
        .IN_W  (ACC_W + 1),
        .OUT_W (ACC_W)
    ) u_sat_acc (
        .val_i (acc_sum),
        .val_o (acc_sat),
        .sat_o (acc_ovf)
    );

    cm3_mac_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_sat_out (
        .val_i (acc_shr),
        .val_o (out_sat),
        .sat_o (out_ovf)
    );

    // Clear wins over any accumulate or output update in the same cycle.
    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        data_mac_d    = data_mac_q;
        acc_upd_vld_d = 1'b0;
        if (bus_io.clear) begin
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            data_mac_d = '0;
        end else begin
            if (p_vld_q) begin
                acc_d         = acc_sat;
                cnt_d         = cnt_inc;
                acc_upd_vld_d = 1'b1;
                if (acc_ovf) ovf_d = 1'b1;
            end
            if (acc_upd_vld_q) begin
                data_mac_d = out_sat;
                if (out_ovf) ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= '0;
            b_q           <= '0;
            a_pend_q      <= 1'b0;
            b_pend_q      <= 1'b0;
            p_q           <= '0;
            p_vld_q       <= 1'b0;
            acc_q         <= '0;
            acc_upd_vld_q <= 1'b0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            data_mac_q    <= '0;
        end else begin
            a_q           <= a_d;
            b_q           <= b_d;
            a_pend_q      <= a_pend_d;
            b_pend_q      <= b_pend_d;
            if (issue) p_q <= p_d;
            p_vld_q       <= issue;
            acc_q         <= acc_d;
            acc_upd_vld_q <= acc_upd_vld_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            data_mac_q    <= data_mac_d;
        end
    end

    assign bus_io.data_mac = data_mac_q;
    assign bus_io.busy     = a_pend_q | b_pend_q | p_vld_q | acc_upd_vld_q;
    assign bus_io.ovf      = ovf_q;
    assign bus_io.mac_cnt  = cnt_q;

endmodule

// File: tb/tb_cm3_mac_core.sv
// Directed vector table plus randomized traffic against a transaction-level MAC model.
module tb_cm3_mac_core;

    logic        hclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        av = 1'b0, bv = 1'b0, clr = 1'b0;
    logic [31:0] da = '0, db = '0;

    always #5 hclk = ~hclk;

    cm3_mac_if #(.DATA_W(32), .CNT_W(16)) if0 ();
    cm3_mac_if #(.DATA_W(32), .CNT_W(16)) if1 ();
    cm3_mac_if #(.DATA_W(32), .CNT_W(3))  if2 ();

    assign if0.data_a = da;  assign if0.data_a_valid = av;
    assign if0.data_b = db;  assign if0.data_b_valid = bv;  assign if0.clear = clr;
    assign if1.data_a = da;  assign if1.data_a_valid = av;
    assign if1.data_b = db;  assign if1.data_b_valid = bv;  assign if1.clear = clr;
    assign if2.data_a = da;  assign if2.data_a_valid = av;
    assign if2.data_b = db;  assign if2.data_b_valid = bv;  assign if2.clear = clr;

    cm3_mac_core #(.DATA_W(32), .ACC_W(64), .FRAC_BITS(0), .CNT_W(16)) dut0 (
        .hclk(hclk), .rst_n(rst_n), .bus_io(if0));
    cm3_mac_core #(.DATA_W(32), .ACC_W(64), .FRAC_BITS(8), .CNT_W(16)) dut1 (
        .hclk(hclk), .rst_n(rst_n), .bus_io(if1));
    cm3_mac_core #(.DATA_W(32), .ACC_W(64), .FRAC_BITS(0), .CNT_W(3)) dut2 (
        .hclk(hclk), .rst_n(rst_n), .bus_io(if2));

    int n_cmp = 0;
    int n_err = 0;
    int ecnt  = 0;

    // Model: pending operands, in-flight products with the edge they land on, math accumulator.
    typedef struct {int due; logic signed [127:0] prod;} fl_t;
    fl_t                 fq[$];
    logic                m_pa, m_pb, m_busy, m_ovf0, m_ovf1;
    logic signed [31:0]  m_va, m_vb;
    logic signed [127:0] m_acc;
    int                  m_cnt;
    logic [31:0]         m_mac0, m_mac1;

    function automatic logic signed [127:0] clampw(input logic signed [127:0] v, input int w,
                                                   output logic hit);
        logic signed [127:0] mx, mn;
        mx  = (128'sd1 <<< (w - 1)) - 128'sd1;
        mn  = -mx - 128'sd1;
        hit = (v > mx) || (v < mn);
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    task automatic model_reset();
        m_pa = 0; m_pb = 0; m_busy = 0; m_ovf0 = 0; m_ovf1 = 0;
        m_va = '0; m_vb = '0; m_acc = '0; m_cnt = 0; m_mac0 = '0; m_mac1 = '0;
        fq.delete();
    endtask

    task automatic model_edge(input logic iav, input logic [31:0] ia, input logic ibv,
                              input logic [31:0] ib, input logic iclr);
        logic signed [127:0] t;
        logic h, upd, ra, rb;
        logic signed [31:0] oa, ob;
        fl_t e;
        upd = 0;
        if (iclr) begin
            m_acc = '0; m_cnt = 0; m_ovf0 = 0; m_ovf1 = 0; m_mac0 = '0; m_mac1 = '0;
            fq.delete();
        end else begin
            t = clampw(m_acc, 32, h);        m_mac0 = t[31:0]; m_ovf0 |= h;
            t = clampw(m_acc >>> 8, 32, h);  m_mac1 = t[31:0]; m_ovf1 |= h;
            while (fq.size() != 0 && fq[0].due == ecnt) begin
                e = fq.pop_front();
                m_acc = clampw(m_acc + e.prod, 64, h);
                m_ovf0 |= h; m_ovf1 |= h;
                m_cnt++;
                upd = 1;
            end
        end
        ra = iav | (m_pa & !iclr);
        rb = ibv | (m_pb & !iclr);
        oa = iav ? ia : m_va;
        ob = ibv ? ib : m_vb;
        if (ra && rb) begin
            e.due  = ecnt + 1;
            e.prod = 128'(oa) * 128'(ob);
            fq.push_back(e);
            m_pa = 0; m_pb = 0;
        end else begin
            m_pa = ra; m_pb = rb;
        end
        if (iav) m_va = ia;
        if (ibv) m_vb = ib;
        m_busy = m_pa | m_pb | (fq.size() != 0) | upd;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    task automatic check_all();
        chk("mac0", 64'(if0.data_mac), 64'(m_mac0));
        chk("mac1_frac8", 64'(if1.data_mac), 64'(m_mac1));
        chk("ovf0", 64'(if0.ovf), 64'(m_ovf0));
        chk("ovf1_frac8", 64'(if1.ovf), 64'(m_ovf1));
        chk("cnt0", 64'(if0.mac_cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
        chk("cnt2_sat", 64'(if2.mac_cnt), 64'((m_cnt > 7) ? 7 : m_cnt));
        chk("busy0", 64'(if0.busy), 64'(m_busy));
    endtask

    task automatic step(input logic iav, input logic [31:0] ia, input logic ibv,
                        input logic [31:0] ib, input logic iclr);
        av = iav; da = ia; bv = ibv; db = ib; clr = iclr;
        @(posedge hclk);
        ecnt++;
        model_edge(iav, ia, ibv, ib, iclr);
        #1;
        check_all();
    endtask

    typedef struct {
        logic        av;
        logic [31:0] a;
        logic        bv;
        logic [31:0] b;
        logic        clr;
        logic        chk;
        logic [31:0] e_mac0;
        logic [31:0] e_mac1;
        int          e_cnt;
        logic        e_ovf;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(input logic iav, input logic [31:0] ia, input logic ibv,
                                input logic [31:0] ib, input logic iclr);
        vec_t v;
        v = '{iav, ia, ibv, ib, iclr, 1'b0, '0, '0, 0, 1'b0, 1'b0};
        return v;
    endfunction

    function automatic vec_t ex(input vec_t v, input logic [31:0] m0, input logic [31:0] m1,
                                input int cnt, input logic ovf, input logic busy);
        vec_t r;
        r = v;
        r.chk = 1; r.e_mac0 = m0; r.e_mac1 = m1; r.e_cnt = cnt; r.e_ovf = ovf; r.e_busy = busy;
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'h7FFF_FFFF;
        if (sel == 1) return 32'h8000_0000;
        if (sel < 6) return 32'($urandom_range(0, 200)) - 32'd100;
        return $urandom;
    endfunction

    localparam int NV = 47;
    vec_t tv[NV];
    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0);
        for (int r = 0; r < NV; r++) tv[r] = idle;
        tv[0]  = mk(1, 3, 0, 0, 0);
        tv[2]  = mk(0, 0, 1, 4, 0);
        tv[3]  = mk(1, -32'sd5, 1, 6, 0);
        tv[4]  = ex(idle, 12, 0, 2, 0, 1);
        tv[5]  = ex(idle, -32'sd18, 32'hFFFF_FFFF, 2, 0, 0);
        tv[6]  = mk(0, 0, 0, 0, 1);
        tv[7]  = ex(idle, 0, 0, 0, 0, 0);
        tv[8]  = mk(1, 7, 0, 0, 0);
        tv[9]  = mk(1, 2, 0, 0, 0);
        tv[10] = mk(0, 0, 1, 10, 0);
        tv[12] = ex(idle, 20, 0, 1, 0, 0);
        tv[13] = mk(1, 1, 1, 1, 0);
        tv[14] = mk(1, 2, 1, 3, 0);
        tv[16] = ex(idle, 27, 0, 3, 0, 0);
        tv[17] = mk(0, 0, 0, 0, 1);
        tv[18] = mk(1, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 0);
        tv[19] = tv[18];
        tv[20] = tv[18];
        tv[22] = ex(idle, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 3, 1, 0);
        tv[23] = ex(mk(0, 0, 0, 0, 1), 0, 0, 0, 0, 0);
        tv[24] = mk(1, 1, 1, 5, 0);
        tv[27] = mk(1, 9, 0, 0, 1);
        tv[28] = mk(0, 0, 1, 9, 0);
        tv[30] = ex(idle, 81, 0, 1, 0, 0);
        tv[31] = mk(1, 4, 1, 4, 0);
        tv[32] = mk(0, 0, 0, 0, 1);
        tv[34] = ex(idle, 0, 0, 0, 0, 0);
        tv[35] = mk(1, 5, 0, 0, 0);
        tv[36] = mk(0, 0, 0, 0, 1);
        tv[37] = mk(0, 0, 1, 6, 0);
        tv[39] = ex(idle, 0, 0, 0, 0, 1);
        tv[40] = mk(1, 2, 0, 0, 0);
        tv[42] = ex(idle, 12, 0, 1, 0, 0);
        tv[43] = mk(0, 0, 0, 0, 1);
        tv[44] = mk(1, 32'h100, 1, 32'h280, 0);
        tv[46] = ex(idle, 32'h2_8000, 32'h280, 1, 0, 0);

        model_reset();
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        rst_n = 1'b1;
        #1;
        chk("reset_mac", 64'(if0.data_mac), 64'd0);
        chk("reset_cnt", 64'(if0.mac_cnt), 64'd0);
        chk("reset_ovf", 64'(if0.ovf), 64'd0);
        chk("reset_busy", 64'(if0.busy), 64'd0);

        for (int r = 0; r < NV; r++) begin
            step(tv[r].av, tv[r].a, tv[r].bv, tv[r].b, tv[r].clr);
            if (tv[r].chk) begin
                chk($sformatf("vec%0d.mac0", r), 64'(if0.data_mac), 64'(tv[r].e_mac0));
                chk($sformatf("vec%0d.mac1", r), 64'(if1.data_mac), 64'(tv[r].e_mac1));
                chk($sformatf("vec%0d.cnt", r), 64'(if0.mac_cnt), 64'(tv[r].e_cnt));
                chk($sformatf("vec%0d.ovf", r), 64'(if0.ovf), 64'(tv[r].e_ovf));
                chk($sformatf("vec%0d.busy", r), 64'(if0.busy), 64'(tv[r].e_busy));
            end
        end

        // Asynchronous reset with a pair and a product in flight.
        step(1, 5, 1, 7, 0);
        step(1, 3, 1, 3, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_mac0", 64'(if0.data_mac), 64'd0);
        chk("midrst_mac1", 64'(if1.data_mac), 64'd0);
        chk("midrst_cnt", 64'(if0.mac_cnt), 64'd0);
        chk("midrst_ovf", 64'(if0.ovf), 64'd0);
        chk("midrst_busy", 64'(if0.busy), 64'd0);
        @(negedge hclk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 45, rnd_op(), $urandom_range(0, 99) < 45, rnd_op(),
                 $urandom_range(0, 99) < 4);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cm3_mac_core.md
Name: cm3_mac_core

Overview:
Multiply-accumulate engine that sits directly downstream of the CM3 MAC AHB register slave. It consumes the slave's operand writes (data_a/data_b with one-cycle valid strobes) and its read-triggered clear pulse. It returns the running, saturated, fixed-point-scaled accumulation on data_mac, which the slave drives straight onto hrdata. Operands are paired: A and B may arrive in either order or in the same cycle, and each completed pair produces one MAC.

Parameters:
DATA_W, 32, operand width and data_mac width; operands are two's-complement signed.
ACC_W, 64, internal accumulator width; must be >= 2*DATA_W.
FRAC_BITS, 0, arithmetic right shift applied to the accumulator before output (Q-format scaling); range 0..DATA_W-1.
CNT_W, 16, width of the MAC-count output.

Ports:
hclk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
data_a  input  DATA_W  operand A, sampled only when data_a_valid=1.
data_a_valid  input  1  single-cycle strobe for operand A.
data_b  input  DATA_W  operand B, sampled only when data_b_valid=1.
data_b_valid  input  1  single-cycle strobe for operand B.
clear  input  1  single-cycle pulse that zeroes the accumulator and status.
data_mac  output  DATA_W  registered, scaled, saturated accumulator value.
busy  output  1  1 while an operand is pending or a product is in flight.
ovf  output  1  sticky saturation flag.
mac_cnt  output  CNT_W  number of MACs accumulated since the last clear.

Behaviour:
- Reset (async, rst_n=0): acc, data_mac, mac_cnt, ovf, pending flags and pipeline valids all go to 0; busy=0.
- Operand capture: data_a_valid loads a_reg and sets a_pend; data_b_valid loads b_reg and sets b_pend.
  - A second A before any B overwrites a_reg (last write wins); the same rule applies to B.
- Issue: a pair issues when A and B are both available. Each operand counts as available if it is already pending or arriving with its strobe that cycle.
  - On issue, both pend flags clear and the operands (arriving values bypass the registers) go to stage 1.
- Pipeline, with issue at cycle T:
  - T+1: p_reg = signed a*b (2*DATA_W bits); p_vld=1.
  - T+2: acc = sat_ACC_W(acc + sext(p_reg)); mac_cnt increments.
  - T+3: data_mac = sat_DATA_W(acc >>> FRAC_BITS).
  - Total latency is 3 cycles from the completing strobe to data_mac. The pipeline is fully pipelined and can accept one pair per cycle.
- Saturation:
  - Accumulator add: clamp to max or min signed ACC_W on overflow and set ovf.
  - Output conversion: clamp to the signed DATA_W range and set ovf.
  - ovf is sticky until clear.
- mac_cnt saturates at all-ones and never wraps.
- busy = a_pend | b_pend | p_vld | acc_upd_vld, where acc_upd_vld is the T+2→T+3 output-pending bit.
- clear (priority over accumulation):
  - Sets acc=0, mac_cnt=0, ovf=0, and data_mac=0 on the next edge.
  - Flushes p_vld, the T+2 stage and the pend flags. A product in flight at the clear edge is discarded.
  - An operand strobe in the same cycle as clear is NOT lost: it is captured as a fresh pending operand after the flush. The slave issues clear one cycle after a read, so it can coincide with the next write's data phase.
  - If that same-cycle strobe completes a pair with another same-cycle strobe, the pair issues normally.
- No back-pressure: strobes are always accepted.
- Reset mid-operation discards everything; there is no partial state.

Decomposition:
- Shared package cm3_mac_pkg holds the default widths, the saturation-limit constants and signed-clamp functions sat_to_acc and sat_to_out.
- One natural sub-module, cm3_mac_sat, implements the parameterised signed saturate-and-flag. It is instantiated twice: the ACC_W add and the DATA_W output.
- The pair/issue logic and the pipeline stay in the top module.

Test Plan:
- Reset then idle → data_mac=0, mac_cnt=0, ovf=0, busy=0.
- A=3, then B=4 two cycles later, then A=-5 and B=6 in the same cycle → data_mac=12 three cycles after the B strobe. data_mac then reaches -18, mac_cnt=2, ovf=0.
- Two strobes A=7 then A=2, followed by B=10 → data_mac=20; proves last-write-wins. Issue two more pairs on back-to-back cycles → one accumulation per cycle, no loss.
- Accumulate 0x7FFFFFFF*0x7FFFFFFF three times → output clamps to 0x7FFFFFFF and ovf=1. Then clear → data_mac=0, ovf=0, mac_cnt=0 on the following cycle.
- Clear in the same cycle as A=9, then B=9 → acc holds 81 only. Clear while a product is in flight → that product is absent from the result.
- FRAC_BITS=8: A=0x100, B=0x280 (1.0×2.5 in Q8) → data_mac=0x280. Assert rst_n low mid-pipeline → all outputs read 0 immediately.
